// File: rtl/inst_mem_pkg.sv
// Shared definitions for the instruction memory: FSM states, the NOP word and
// MIPS opcode/funct encodings used by the decoder and the benches.
package inst_mem_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        LOAD  = 2'd2
    } inst_mem_state_t;

    localparam logic [31:0] INST_NOP = 32'h00000000;

    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;

endpackage

// File: rtl/inst_mem_ram.sv
// Single-port synchronous RAM; a write takes priority and leaves rdata untouched,
// so rdata only changes on an enabled read.
module inst_mem_ram #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 256,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/inst_fetch_mem.sv
// Instruction memory with a 1-cycle fetch handshake, a streaming load port and
// a post-reset sweep that fills every word with NOP.
module inst_fetch_mem
    import inst_mem_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 256,
    parameter  int ADDR_W = 32,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic [DATA_W-1:0] inst,
    output logic              inst_valid,
    output logic              fetch_err,
    input  logic              ld_start,
    input  logic [IDX_W-1:0]  ld_base,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic [IDX_W:0]    ld_cnt,
    output logic              busy
);

    inst_mem_state_t   state;
    logic [IDX_W-1:0]  ptr;
    logic              beat;
    logic              accept;
    logic              bad_addr;
    logic              ram_we;
    logic              ram_re;
    logic [IDX_W-1:0]  ram_idx;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              vld_p1;
    logic              err_p1;
    logic              hit_p1;

    assign fetch_ready = (state == IDLE) && !ld_start;
    assign ld_ready    = (state == LOAD);
    assign busy        = (state != IDLE);
    assign beat        = ld_ready && ld_valid;
    assign accept      = fetch_req && fetch_ready;
    assign bad_addr    = (fetch_addr[1:0] != 2'b00) || ((fetch_addr >> (IDX_W + 2)) != '0);

    // The FSM owns the single port: sweep/load writes at ptr, fetch reads in IDLE.
    assign ram_we    = rst_n && ((state == CLEAR) || beat);
    assign ram_re    = rst_n && accept && !bad_addr;
    assign ram_idx   = (state == IDLE) ? fetch_addr[IDX_W+1:2] : ptr;
    assign ram_wdata = (state == LOAD) ? ld_data : DATA_W'(INST_NOP);

    inst_mem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .idx   (ram_idx),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= CLEAR;
            ptr    <= '0;
            ld_cnt <= '0;
        end else begin
            unique case (state)
                CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == IDX_W'(DEPTH - 1)) state <= IDLE;
                end
                IDLE: begin
                    if (ld_start) begin
                        ptr    <= ld_base;
                        ld_cnt <= '0;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        ptr    <= ptr + 1'b1;
                        ld_cnt <= ld_cnt + 1'b1;
                        if (ld_last) state <= IDLE;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Fetch response stage: error and hit flags hold until the next accepted fetch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
            hit_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                err_p1 <= bad_addr;
                hit_p1 <= !bad_addr;
            end
        end
    end

    assign inst_valid = vld_p1;
    assign fetch_err  = err_p1;
    assign inst       = hit_p1 ? ram_rdata : '0;

endmodule

// File: tb/tb_inst_fetch_mem.sv
// Randomized and directed bench for inst_fetch_mem against an array-based memory model.
module tb_inst_fetch_mem;

    localparam int DEPTH = 256;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic [31:0] inst;
    logic        inst_valid;
    logic        fetch_err;
    logic        ld_start;
    logic [7:0]  ld_base;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic [8:0]  ld_cnt;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem_m  [DEPTH];
    logic [31:0] ld_buf [16];

    inst_fetch_mem dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .fetch_err   (fetch_err),
        .ld_start    (ld_start),
        .ld_base     (ld_base),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .ld_cnt      (ld_cnt),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_fetch(input logic [31:0] a, output logic [31:0] e_inst,
                                        output logic e_err);
        e_err  = (a % 4 != 0) || (a >= 32'(DEPTH * 4));
        e_inst = e_err ? 32'h0 : mem_m[(a / 4) % DEPTH];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic do_fetch(input logic [31:0] a, output logic rdy, output logic vld,
                            output logic [31:0] ins, output logic err);
        fetch_addr = a;
        fetch_req  = 1'b1;
        #1 rdy = fetch_ready;
        @(posedge clk); #1;
        fetch_req = 1'b0;
        vld = inst_valid;
        ins = inst;
        err = fetch_err;
    endtask

    task automatic do_load(input int base, input int n);
        ld_start = 1'b1;
        ld_base  = 8'(base);
        @(posedge clk); #1;
        ld_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1;
            ld_data  = ld_buf[i];
            ld_last  = (i == n - 1);
            @(posedge clk); #1;
            mem_m[(base + i) % DEPTH] = ld_buf[i];
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        logic rdy, vld, err;
        logic [31:0] ins;
        rst_n = 1'b0;
        fetch_req = 1'b0; fetch_addr = '0;
        ld_start = 1'b0; ld_base = '0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_clear();
        n_cmp++;
        if (busy !== 1'b1 || fetch_ready !== 1'b0 || ld_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: busy=%b fetch_ready=%b ld_ready=%b, required 1 0 0",
                     busy, fetch_ready, ld_ready);
        end
        n_cmp++;
        if (inst !== 32'h0 || inst_valid !== 1'b0 || fetch_err !== 1'b0 || ld_cnt !== 9'd0) begin
            n_bad++;
            $display("FAIL reset_out: inst=%h vld=%b err=%b ld_cnt=%0d, required 0 0 0 0",
                     inst, inst_valid, fetch_err, ld_cnt);
        end
        rst_n = 1'b1;
        wait_clear(n);
        n_cmp++;
        if (n != DEPTH) begin
            n_bad++;
            $display("FAIL clear_len: busy cycles=%0d, required %0d", n, DEPTH);
        end
        do_fetch(32'h3FC, rdy, vld, ins, err);
        n_cmp++;
        if (rdy !== 1'b1 || vld !== 1'b1 || ins !== 32'h0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL fetch_after_clear: rdy=%b vld=%b inst=%h err=%b, required 1 1 0 0",
                     rdy, vld, ins, err);
        end
    endtask

    task automatic test_load_fetch();
        logic rdy, vld, err;
        logic [31:0] ins;
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h24210004; exp_w[1] = 32'h8C220000; exp_w[2] = 32'h08000004;
        for (int i = 0; i < 3; i++) ld_buf[i] = exp_w[i];
        do_load(1, 3);
        n_cmp++;
        if (ld_cnt !== 9'd3 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL load_cnt: ld_cnt=%0d busy=%b, required 3 0", ld_cnt, busy);
        end
        for (int i = 0; i < 3; i++) begin
            do_fetch(32'(4 * (i + 1)), rdy, vld, ins, err);
            n_cmp++;
            if (vld !== 1'b1 || ins !== exp_w[i] || err !== 1'b0) begin
                n_bad++;
                $display("FAIL load_fetch[%0d]: vld=%b inst=%h err=%b, required 1 %h 0",
                         i, vld, ins, err, exp_w[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic rdy, vld, err;
        logic [31:0] ins;
        logic [31:0] wa, wb;
        wa = $urandom; wb = $urandom;
        ld_buf[0] = wa; ld_buf[1] = wb;
        do_load(255, 2);
        n_cmp++;
        if (ld_cnt !== 9'd2) begin
            n_bad++;
            $display("FAIL wrap_cnt: ld_cnt=%0d, required 2", ld_cnt);
        end
        do_fetch(32'h3FC, rdy, vld, ins, err);
        n_cmp++;
        if (ins !== wa || err !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_255: inst=%h err=%b, required %h 0", ins, err, wa);
        end
        do_fetch(32'h0, rdy, vld, ins, err);
        n_cmp++;
        if (ins !== wb || err !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_0: inst=%h err=%b, required %h 0", ins, err, wb);
        end
    endtask

    task automatic test_errors();
        logic rdy, vld, err;
        logic [31:0] ins;
        do_fetch(32'h6, rdy, vld, ins, err);
        n_cmp++;
        if (vld !== 1'b1 || ins !== 32'h0 || err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_misalign: vld=%b inst=%h err=%b, required 1 0 1", vld, ins, err);
        end
        do_fetch(32'h400, rdy, vld, ins, err);
        n_cmp++;
        if (vld !== 1'b1 || ins !== 32'h0 || err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_range: vld=%b inst=%h err=%b, required 1 0 1", vld, ins, err);
        end
        do_fetch(32'h4, rdy, vld, ins, err);
        n_cmp++;
        if (ins !== 32'h24210004 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clear: inst=%h err=%b, required 24210004 0", ins, err);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (inst_valid !== 1'b0 || inst !== 32'h24210004 || fetch_err !== 1'b0) begin
            n_bad++;
            $display("FAIL hold: vld=%b inst=%h err=%b, required 0 24210004 0",
                     inst_valid, inst, fetch_err);
        end
    endtask

    task automatic test_collision();
        ld_start = 1'b1; ld_base = 8'd20;
        fetch_req = 1'b1; fetch_addr = 32'd80;
        #1;
        n_cmp++;
        if (fetch_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL collide_ready: fetch_ready=%b, required 0", fetch_ready);
        end
        @(posedge clk); #1;
        ld_start = 1'b0;
        n_cmp++;
        if (inst_valid !== 1'b0 || ld_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL collide_vld: inst_valid=%b ld_ready=%b, required 0 1", inst_valid, ld_ready);
        end
        for (int i = 0; i < 3; i++) begin
            ld_buf[i] = $urandom;
            ld_valid = 1'b1; ld_data = ld_buf[i]; ld_last = (i == 2);
            #1;
            n_cmp++;
            if (fetch_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_ready[%0d]: fetch_ready=%b, required 0", i, fetch_ready);
            end
            @(posedge clk); #1;
            mem_m[20 + i] = ld_buf[i];
            n_cmp++;
            if (inst_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_vld[%0d]: inst_valid=%b, required 0", i, inst_valid);
            end
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        #1;
        n_cmp++;
        if (fetch_ready !== 1'b1 || ld_cnt !== 9'd3) begin
            n_bad++;
            $display("FAIL bp_release: fetch_ready=%b ld_cnt=%0d, required 1 3", fetch_ready, ld_cnt);
        end
        @(posedge clk); #1;
        fetch_req = 1'b0;
        n_cmp++;
        if (inst_valid !== 1'b1 || inst !== ld_buf[0] || fetch_err !== 1'b0) begin
            n_bad++;
            $display("FAIL read_after_load: vld=%b inst=%h err=%b, required 1 %h 0",
                     inst_valid, inst, fetch_err, ld_buf[0]);
        end
    endtask

    task automatic test_random();
        logic [31:0] addrs [8];
        logic [31:0] e_inst;
        logic e_err;
        int len, base, kind;
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(2) == 0) begin
                len  = $urandom_range(6, 1);
                base = $urandom_range(DEPTH - 1);
                for (int i = 0; i < len; i++) ld_buf[i] = $urandom;
                do_load(base, len);
                n_cmp++;
                if (ld_cnt !== 9'(len)) begin
                    n_bad++;
                    $display("FAIL rnd_cnt: ld_cnt=%0d, required %0d", ld_cnt, len);
                end
            end else begin
                len = $urandom_range(8, 1);
                for (int i = 0; i < len; i++) begin
                    kind = $urandom_range(9);
                    if (kind == 0)      addrs[i] = $urandom;
                    else if (kind == 1) addrs[i] = 32'($urandom_range(1023));
                    else                addrs[i] = 32'($urandom_range(DEPTH - 1)) << 2;
                end
                fetch_req  = 1'b1;
                fetch_addr = addrs[0];
                for (int i = 0; i < len; i++) begin
                    @(posedge clk); #1;
                    model_fetch(addrs[i], e_inst, e_err);
                    n_cmp++;
                    if (inst_valid !== 1'b1 || inst !== e_inst || fetch_err !== e_err) begin
                        n_bad++;
                        $display("FAIL rnd_fetch addr=%h: vld=%b inst=%h err=%b, required 1 %h %b",
                                 addrs[i], inst_valid, inst, fetch_err, e_inst, e_err);
                    end
                    if (i < len - 1) fetch_addr = addrs[i + 1];
                    else fetch_req = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset_mid_load();
        int n;
        logic [31:0] e_inst;
        logic e_err;
        ld_start = 1'b1; ld_base = 8'd40;
        @(posedge clk); #1;
        ld_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1; ld_data = $urandom; ld_last = 1'b0;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        ld_valid = 1'b0;
        model_clear();
        n_cmp++;
        if (busy !== 1'b1 || ld_ready !== 1'b0 || fetch_ready !== 1'b0 || ld_cnt !== 9'd0) begin
            n_bad++;
            $display("FAIL abort: busy=%b ld_ready=%b fetch_ready=%b ld_cnt=%0d, required 1 0 0 0",
                     busy, ld_ready, fetch_ready, ld_cnt);
        end
        rst_n = 1'b1;
        wait_clear(n);
        n_cmp++;
        if (n != DEPTH) begin
            n_bad++;
            $display("FAIL reclear_len: busy cycles=%0d, required %0d", n, DEPTH);
        end
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            @(posedge clk); #1;
            model_fetch(32'(4 * i), e_inst, e_err);
            n_cmp++;
            if (inst_valid !== 1'b1 || inst !== e_inst || fetch_err !== e_err) begin
                n_bad++;
                $display("FAIL erased[%0d]: vld=%b inst=%h err=%b, required 1 %h %b",
                         i, inst_valid, inst, fetch_err, e_inst, e_err);
            end
            fetch_addr = 32'(4 * (i + 1));
        end
        fetch_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_fetch();
        test_wrap();
        test_errors();
        test_collision();
        test_random();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
